// File: rtl/key_voice_alloc.sv
// key_voice_alloc: the stage between the 4x4 key-matrix scanner and the organ
// tone generators. It latches the scanner bitmap on each frame strobe and
// debounces every key against that frame. It then walks the keys one per
// cycle, hands pressed keys to a fixed pool of voices and frees voices on
// release. Every assignment or release is reported as a one-cycle event.

module key_voice_alloc #(
  parameter int NUM_KEYS   = 16,
  parameter int NUM_VOICES = 4,
  parameter int DEB_SCANS  = 3,
  localparam int KW = $clog2(NUM_KEYS),
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      key,
  input  logic                     tc,
  output logic [NUM_KEYS-1:0]      stable_keys,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic [NUM_VOICES*KW-1:0] voice_key,
  output logic                     note_on,
  output logic                     note_off,
  output logic                     note_drop,
  output logic [KW-1:0]            ev_key,
  output logic [VW-1:0]            ev_voice,
  output logic                     busy
);

  // The counter never has to hold more than DEB_SCANS, because it clears on reaching it.
  localparam int CW = $clog2(DEB_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state;
  logic                tc_q;
  logic                pend;
  logic [NUM_KEYS-1:0] cap;
  logic [NUM_KEYS-1:0] chg;
  logic [NUM_KEYS-1:0] voiced;
  logic [KW-1:0]       idx;
  logic [CW-1:0]       cnt [NUM_KEYS];

  logic                tc_rise;
  logic                free_found;
  logic [VW-1:0]       free_v;
  logic                match_found;
  logic [VW-1:0]       match_v;

  assign tc_rise = tc & ~tc_q;
  assign busy    = (state != IDLE);

  // Find the lowest free voice, and the voice that is sounding the key under the service pointer.
  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path leaves it unassigned and no latch is inferred.
    free_found  = 1'b0;
    free_v      = '0;
    match_found = 1'b0;
    match_v     = '0;
    // Scan from the top down so that the last hit, which is the lowest index, wins.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_v     = VW'(v);
      end
      if (voice_active[v] && (voice_key[v*KW +: KW] == idx)) begin
        match_found = 1'b1;
        match_v     = VW'(v);
      end
    end
  end

  // Frame capture, debounce, the key-service FSM and the registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the debounce counter array is cleared explicitly. Each counter is real per-key
      // state and must start at zero, so this array cannot stay uninitialised like a RAM.
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
      state        <= IDLE;
      tc_q         <= 1'b0;
      pend         <= 1'b0;
      cap          <= '0;
      chg          <= '0;
      voiced       <= '0;
      idx          <= '0;
      stable_keys  <= '0;
      voice_active <= '0;
      voice_key    <= '0;
      note_on      <= 1'b0;
      note_off     <= 1'b0;
      note_drop    <= 1'b0;
      ev_key       <= '0;
      ev_voice     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the state from before this edge.
      tc_q      <= tc;
      note_on   <= 1'b0;
      note_off  <= 1'b0;
      note_drop <= 1'b0;

      // A frame edge is captured in any state. Edges that arrive while busy merge: the newest bitmap wins.
      if (tc_rise) cap <= key;

      // IDLE consumes a pending frame, and also an edge that arrives in the same cycle.
      // That way DEB follows the edge directly.
      if ((state == IDLE) && (pend || tc_rise)) pend <= 1'b0;
      else if (tc_rise)                         pend <= 1'b1;

      case (state)
        IDLE: begin
          if (pend || tc_rise) state <= DEB;
        end

        DEB: begin
          for (int k = 0; k < NUM_KEYS; k++) begin
            if (cap[k] == stable_keys[k]) begin
              cnt[k] <= '0;
            end else if (int'(cnt[k]) + 1 == DEB_SCANS) begin
              cnt[k]         <= '0;
              stable_keys[k] <= ~stable_keys[k];
              chg[k]         <= 1'b1;
            end else begin
              cnt[k] <= cnt[k] + CW'(1);
            end
          end
          idx   <= '0;
          state <= SERVICE;
        end

        SERVICE: begin
          if (chg[idx]) begin
            chg[idx] <= 1'b0;
            if (stable_keys[idx]) begin
              if (free_found) begin
                voice_active[free_v]              <= 1'b1;
                voice_key[int'(free_v)*KW +: KW]  <= idx;
                voiced[idx]                       <= 1'b1;
                note_on                           <= 1'b1;
                ev_key                            <= idx;
                ev_voice                          <= free_v;
              end else begin
                // No free voice: the key is dropped and stays unvoiced until it is released.
                note_drop <= 1'b1;
                ev_key    <= idx;
              end
            end else if (voiced[idx]) begin
              voiced[idx] <= 1'b0;
              if (match_found) begin
                voice_active[match_v] <= 1'b0;
                note_off              <= 1'b1;
                ev_key                <= idx;
                ev_voice              <= match_v;
              end
            end
          end
          if (idx == KW'(NUM_KEYS - 1)) state <= IDLE;
          else                          idx   <= idx + KW'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_voice_alloc.sv
// Directed bench for key_voice_alloc. It runs reset, debounce, voice
// allocation with overflow, merged frames and a mid-service reset. Events are
// logged by a negedge monitor and compared against hand-computed sequences.

module tb_key_voice_alloc;

  logic        clk;
  logic        rst;
  logic [15:0] key;
  logic        tc;
  logic [15:0] stable_keys;
  logic [3:0]  voice_active;
  logic [15:0] voice_key;
  logic        note_on;
  logic        note_off;
  logic        note_drop;
  logic [3:0]  ev_key;
  logic [1:0]  ev_voice;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Event log filled by the monitor: code = type<<16 | key<<8 | voice (1=on, 2=off, 3=drop).
  logic [31:0] ev_log [$];
  int          ev_cyc [$];
  int          cyc = 0;
  int          rise_cyc = 0;
  int          busy_rises = 0;
  int          multi = 0;
  logic        busy_prev = 1'b0;

  key_voice_alloc dut (
    .clk          (clk),
    .rst          (rst),
    .key          (key),
    .tc           (tc),
    .stable_keys  (stable_keys),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .note_on      (note_on),
    .note_off     (note_off),
    .note_drop    (note_drop),
    .ev_key       (ev_key),
    .ev_voice     (ev_voice),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(note_on) + int'(note_off) + int'(note_drop) > 1) multi <= multi + 1;
    if (note_on)   begin ev_log.push_back(ev(1, int'(ev_key), int'(ev_voice))); ev_cyc.push_back(cyc); end
    if (note_off)  begin ev_log.push_back(ev(2, int'(ev_key), int'(ev_voice))); ev_cyc.push_back(cyc); end
    if (note_drop) begin ev_log.push_back(ev(3, int'(ev_key), 0));              ev_cyc.push_back(cyc); end
    if (busy && !busy_prev) busy_rises <= busy_rises + 1;
    busy_prev <= busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ev(input int t, input int k, input int v);
    return 32'((t << 16) | (k << 8) | v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input int i, input logic [31:0] exp);
    check(tag, (i < ev_log.size()) ? ev_log[i] : 32'hDEAD_BEEF, exp);
  endtask

  task automatic clear_log();
    ev_log.delete();
    ev_cyc.delete();
  endtask

  // Wait until the DUT has been idle for three straight cycles, or the cycle budget runs out.
  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) quiet++;
      else quiet = 0;
    end
    check("idle_reached", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  // One scanner frame: present the bitmap, raise tc for one cycle, then let the DUT finish.
  task automatic frame(input logic [15:0] k);
    key = k;
    tc  = 1'b1;
    @(posedge clk); #1;
    rise_cyc = cyc;
    tc = 1'b0;
    wait_idle();
  endtask

  initial begin
    // ---- 1: reset held with the inputs active ----
    rst = 1'b1;
    key = 16'hFFFF;
    tc  = 1'b0;
    @(posedge clk); #1; tc = 1'b1;
    @(posedge clk); #1; tc = 1'b0;
    @(negedge clk);
    check("rst_stable",  32'(stable_keys), 32'h0);
    check("rst_vactive", 32'(voice_active), 32'h0);
    check("rst_vkey",    32'(voice_key), 32'h0);
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_pulses",  32'({note_on, note_off, note_drop}), 32'h0);
    check("rst_evkey",   32'(ev_key), 32'h0);
    check("rst_evvoice", 32'(ev_voice), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    key = 16'h0000;
    clear_log();

    // ---- 2: key 5 held for three frames ----
    frame(16'h0020);
    frame(16'h0020);
    check("t2_no_ev_early", 32'(ev_log.size()), 32'd0);
    check("t2_stable_early", 32'(stable_keys), 32'h0);
    frame(16'h0020);
    check("t2_ev_count", 32'(ev_log.size()), 32'd1);
    chk_ev("t2_on_k5_v0", 0, ev(1, 5, 0));
    check("t2_latency", 32'((ev_cyc.size() > 0) ? ev_cyc[0] - rise_cyc : -1), 32'd7);
    check("t2_stable", 32'(stable_keys), 32'h0020);
    check("t2_vactive", 32'(voice_active), 32'h1);
    check("t2_vkey0", 32'(voice_key[3:0]), 32'd5);
    clear_log();
    frame(16'h0000); frame(16'h0000); frame(16'h0000);
    check("t2_rel_count", 32'(ev_log.size()), 32'd1);
    chk_ev("t2_off_k5_v0", 0, ev(2, 5, 0));
    check("t2_rel_vactive", 32'(voice_active), 32'h0);
    check("t2_vkey_held", 32'(voice_key[3:0]), 32'd5);
    clear_log();

    // ---- 3: bounce on key 2 restarts the count ----
    frame(16'h0004); frame(16'h0000); frame(16'h0004); frame(16'h0004);
    check("t3_no_ev_4frames", 32'(ev_log.size()), 32'd0);
    frame(16'h0004);
    check("t3_ev_count", 32'(ev_log.size()), 32'd1);
    chk_ev("t3_on_k2_v0", 0, ev(1, 2, 0));
    clear_log();
    frame(16'h0000); frame(16'h0000); frame(16'h0000);
    chk_ev("t3_off_k2_v0", 0, ev(2, 2, 0));
    clear_log();

    // ---- 4: five keys into four voices ----
    frame(16'h121A); frame(16'h121A); frame(16'h121A);
    check("t4_ev_count", 32'(ev_log.size()), 32'd5);
    chk_ev("t4_on_k1_v0", 0, ev(1, 1, 0));
    chk_ev("t4_on_k3_v1", 1, ev(1, 3, 1));
    chk_ev("t4_on_k4_v2", 2, ev(1, 4, 2));
    chk_ev("t4_on_k9_v3", 3, ev(1, 9, 3));
    chk_ev("t4_drop_k12", 4, ev(3, 12, 0));
    check("t4_vactive", 32'(voice_active), 32'hF);
    check("t4_vkey", 32'(voice_key), 32'h9431);
    clear_log();
    frame(16'h1212); frame(16'h1212); frame(16'h1212);
    check("t4_rel3_count", 32'(ev_log.size()), 32'd1);
    chk_ev("t4_off_k3_v1", 0, ev(2, 3, 1));
    check("t4_rel3_vactive", 32'(voice_active), 32'hD);
    check("t4_vkey_held", 32'(voice_key), 32'h9431);
    clear_log();
    frame(16'h0212); frame(16'h0212); frame(16'h0212);
    check("t4_rel12_no_ev", 32'(ev_log.size()), 32'd0);
    check("t4_rel12_vactive", 32'(voice_active), 32'hD);
    check("t4_rel12_stable", 32'(stable_keys), 32'h0212);
    clear_log();

    // ---- 5: three frame edges during one SERVICE merge into one DEB pass ----
    busy_rises = 0;
    key = 16'h0212;
    tc  = 1'b1;
    @(posedge clk); #1; tc = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    key = 16'h0400; tc = 1'b1; @(posedge clk); #1; tc = 1'b0; @(posedge clk); #1;
    key = 16'h0800; tc = 1'b1; @(posedge clk); #1; tc = 1'b0; @(posedge clk); #1;
    key = 16'h0001; tc = 1'b1; @(posedge clk); #1; tc = 1'b0; @(posedge clk); #1;
    wait_idle();
    check("t5_deb_passes", 32'(busy_rises), 32'd2);
    check("t5_no_ev", 32'(ev_log.size()), 32'd0);
    check("t5_stable_held", 32'(stable_keys), 32'h0212);
    frame(16'h0001); frame(16'h0001);
    check("t5_ev_count", 32'(ev_log.size()), 32'd4);
    chk_ev("t5_on_k0_v1", 0, ev(1, 0, 1));
    chk_ev("t5_off_k1_v0", 1, ev(2, 1, 0));
    chk_ev("t5_off_k4_v2", 2, ev(2, 4, 2));
    chk_ev("t5_off_k9_v3", 3, ev(2, 9, 3));
    check("t5_stable", 32'(stable_keys), 32'h0001);
    check("t5_vactive", 32'(voice_active), 32'h2);
    check("t5_vkey", 32'(voice_key), 32'h9401);
    clear_log();

    // ---- 6: reset in the middle of a SERVICE pass ----
    frame(16'h121A); frame(16'h121A);
    key = 16'h121A;
    tc  = 1'b1;
    @(posedge clk); #1; tc = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    @(negedge clk);
    check("t6_pulses", 32'({note_on, note_off, note_drop}), 32'h0);
    check("t6_vactive", 32'(voice_active), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_stable", 32'(stable_keys), 32'h0);
    @(posedge clk); #1;
    wait_idle();
    check("t6_no_ev_after_rst", 32'(ev_log.size()), 32'd0);
    frame(16'h0028); frame(16'h0028); frame(16'h0028);
    check("t6_ev_count", 32'(ev_log.size()), 32'd2);
    chk_ev("t6_on_k3_v0", 0, ev(1, 3, 0));
    chk_ev("t6_on_k5_v1", 1, ev(1, 5, 1));
    check("t6_vactive_re", 32'(voice_active), 32'h3);

    check("pulse_exclusive", 32'(multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
